// File: rtl/wb_addr_dec_if.sv
// -----------------------------------------------------------------------------
// wb_addr_dec_if
//
// Master-side Wishbone bus between the request translator and the address
// decoder. The signal names match the decoder's port names, so the suffix
// shows the direction as seen from the decoder.
//
//   cyc_i      master cycle
//   stb_i      master strobe
//   adr_i      30-bit word address
//   ack_o      registered acknowledge, one-cycle pulse
//   err_o      registered bus error, one-cycle pulse
//   dat_o      registered read data
//   err_adr_o  address of the most recent errored access
//
// Modports:
//   master  the requester (CPU / translator) side
//   slave   the decoder side
// -----------------------------------------------------------------------------
interface wb_addr_dec_if;

  logic        cyc_i;
  logic        stb_i;
  logic [29:0] adr_i;
  logic        ack_o;
  logic        err_o;
  logic [31:0] dat_o;
  logic [29:0] err_adr_o;

  modport master (
    output cyc_i, stb_i, adr_i,
    input  ack_o, err_o, dat_o, err_adr_o
  );

  modport slave (
    input  cyc_i, stb_i, adr_i,
    output ack_o, err_o, dat_o, err_adr_o
  );

endinterface

// File: rtl/wb_addr_dec.sv
// -----------------------------------------------------------------------------
// wb_addr_dec
//
// Parametrised Wishbone address decoder and response multiplexer. A bit field
// of the word address, adr_i[SEL_HI:SEL_LO], selects one of SLAVES targets.
// The selected slave gets a strobe, and its acknowledge and read data are
// registered back to the master. An access to an index >= SLAVES is unmapped
// and ends with a one-cycle bus error, so the CPU never hangs on a hole in the
// map. When WB_ADDR_DEC_TIMEOUT_EN is defined, a slave that stays silent for
// TIMEOUT cycles also ends the access with a bus error.
//
// Parameters:
//   SLAVES   number of slave ports, 1..16
//   SEL_HI   MSB of the slave-index field in adr_i
//   SEL_LO   LSB of the slave-index field; 2**(SEL_HI-SEL_LO+1) >= SLAVES
//   TIMEOUT  maximum cycles spent waiting on a slave, 1..65535
//            (used only with WB_ADDR_DEC_TIMEOUT_EN)
//
// Compile-time option:
//   WB_ADDR_DEC_TIMEOUT_EN  defined   : timeout counter and timeout error path
//                                       are built in
//                           undefined : the decoder waits indefinitely for an
//                                       ack or a master abort
//
// Ports:
//   clk_i      system clock, the only clock domain
//   rst_i      synchronous active-high reset
//   bus        master-side Wishbone bus (wb_addr_dec_if.slave)
//   slv_stb_o  per-slave strobe, one-hot or zero
//   slv_ack_i  per-slave acknowledge
//   slv_dat_i  per-slave read data; slave n sits at [n*32+31:n*32]
//
// Timing (a request is first seen in IDLE in cycle 0):
//   mapped    slave strobe from cycle 1; a slave ack in cycle k gives ack_o
//             and dat_o in cycle k+1
//   unmapped  err_o in cycle 1; no slave is strobed
//   RESP always returns to IDLE, so a new request is accepted in the cycle
//   after a response.
// -----------------------------------------------------------------------------
module wb_addr_dec #(
  parameter int SLAVES  = 8,
  parameter int SEL_HI  = 29,
  parameter int SEL_LO  = 26,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_addr_dec_if.slave           bus,
  output logic [SLAVES-1:0]      slv_stb_o,
  input  logic [SLAVES-1:0]      slv_ack_i,
  input  logic [SLAVES*32-1:0]   slv_dat_i
);

  localparam int SEL_W = SEL_HI - SEL_LO + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_reg,   state_next;
  logic [SEL_W-1:0] idx_reg,     idx_next;
  logic             ack_reg,     ack_next;
  logic             err_reg,     err_next;
  logic [31:0]      dat_reg,     dat_next;
  logic [29:0]      err_adr_reg, err_adr_next;

`ifdef WB_ADDR_DEC_TIMEOUT_EN
  // Cycles already spent in ACTIVE. The counter stops at TIMEOUT-1 because
  // the access is terminated on that cycle, so it never wraps.
  logic [15:0] cnt_reg, cnt_next;
  // The full request address is kept so that a timeout reports where the
  // access went, even though the master may have moved adr_i since.
  logic [29:0] adr_reg, adr_next;
  logic        timeout_hit;

  assign timeout_hit = (cnt_reg == 16'(TIMEOUT - 1));
`else
  // Without the timeout path nothing depends on TIMEOUT.
  localparam int unused_timeout = TIMEOUT;
`endif

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] req_idx;
  logic             req_mapped;
  logic             req_valid;

  assign req_idx    = bus.adr_i[SEL_HI:SEL_LO];
  assign req_mapped = (32'(req_idx) < 32'(SLAVES));
  assign req_valid  = bus.cyc_i & bus.stb_i;

  // ---------------------------------------------------------------------------
  // Selected-slave view, built from the latched index. Each slave compares
  // its own number against the index, and the ack and data are then reduced
  // with OR. Acks and data from the other slaves are masked off here, so
  // they cannot reach the response path in any state.
  // ---------------------------------------------------------------------------
  logic [SLAVES-1:0] sel_onehot;
  logic [31:0]       sel_dat_masked [SLAVES];
  logic [31:0]       sel_dat;
  logic              sel_ack;

  generate
    for (genvar gi = 0; gi < SLAVES; gi++) begin : g_slv
      assign sel_onehot[gi]     = (idx_reg == SEL_W'(gi));
      assign sel_dat_masked[gi] = sel_onehot[gi] ? slv_dat_i[gi*32 +: 32] : 32'd0;
    end
  endgenerate

  always_comb begin
    sel_dat = 32'd0;
    for (int i = 0; i < SLAVES; i++) begin
      sel_dat = sel_dat | sel_dat_masked[i];
    end
  end

  assign sel_ack = |(slv_ack_i & sel_onehot);

  // The strobe is combinational from the state and the latched index. It
  // follows the master's cyc/stb, so an abort removes it in the same cycle.
  // In RESP it is forced low, so a slave can never see a second strobe for
  // a request that has already been answered.
  assign slv_stb_o = ((state_reg == ST_ACTIVE) && bus.cyc_i && bus.stb_i)
                     ? sel_onehot : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    ack_next     = 1'b0;            // ack/err are single-cycle pulses
    err_next     = 1'b0;
    dat_next     = dat_reg;         // read data holds between responses
    err_adr_next = err_adr_reg;
`ifdef WB_ADDR_DEC_TIMEOUT_EN
    cnt_next     = cnt_reg;
    adr_next     = adr_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          idx_next = req_idx;
          if (req_mapped) begin
            state_next = ST_ACTIVE;
`ifdef WB_ADDR_DEC_TIMEOUT_EN
            cnt_next   = 16'd0;
            adr_next   = bus.adr_i;
`endif
          end else begin
            // Hole in the map: answer with an error straight away, without
            // strobing any slave.
            state_next   = ST_RESP;
            err_next     = 1'b1;
            dat_next     = 32'd0;
            err_adr_next = bus.adr_i;
          end
        end
      end

      ST_ACTIVE: begin
        // The order of these tests matters. An ack wins over an abort in
        // the same cycle. An ack in the last allowed cycle also wins over
        // the timeout.
        if (sel_ack) begin
          state_next = ST_RESP;
          ack_next   = 1'b1;
          dat_next   = sel_dat;
        end else if (!bus.cyc_i) begin
          // Master abort: drop the access silently.
          state_next = ST_IDLE;
`ifdef WB_ADDR_DEC_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_next   = ST_RESP;
          err_next     = 1'b1;
          dat_next     = 32'd0;
          err_adr_next = adr_reg;
        end else begin
          cnt_next = cnt_reg + 16'd1;
`endif
        end
      end

      // RESP always lasts one cycle, and stb_i is not looked at. The unused
      // encoding also recovers to IDLE.
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Reset also clears ack/err, so a response that was scheduled for the cycle
  // after the reset edge is lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      dat_reg     <= 32'd0;
      err_adr_reg <= 30'd0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      dat_reg     <= dat_next;
      err_adr_reg <= err_adr_next;
    end
  end

`ifdef WB_ADDR_DEC_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= 16'd0;
      adr_reg <= 30'd0;
    end else begin
      cnt_reg <= cnt_next;
      adr_reg <= adr_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ack_o     = ack_reg;
  assign bus.err_o     = err_reg;
  assign bus.dat_o     = dat_reg;
  assign bus.err_adr_o = err_adr_reg;

endmodule

// File: tb/tb_wb_addr_dec.sv
// -----------------------------------------------------------------------------
// tb_wb_addr_dec
//
// Self-checking bench for wb_addr_dec with SLAVES=6, SEL=[29:26] and TIMEOUT=6.
// The outcome of each transaction is worked out in advance from the decoder's
// rules. The time the selected slave acks (k), the time the master aborts (a)
// and the timeout T are compared:
//   - the earliest of the three ends the access;
//   - ack wins ties, then abort, then timeout.
// From that outcome the bench derives the expected strobe, ack, err, dat and
// err_adr in every cycle. Without WB_ADDR_DEC_TIMEOUT_EN, T is treated as
// infinite.
// -----------------------------------------------------------------------------
module tb_wb_addr_dec;

  localparam int SLAVES  = 6;
  localparam int SEL_HI  = 29;
  localparam int SEL_LO  = 26;
  localparam int TIMEOUT = 6;
  localparam int NEVER   = 1 << 30;

`ifdef WB_ADDR_DEC_TIMEOUT_EN
  localparam int T_EFF = TIMEOUT;
`else
  localparam int T_EFF = NEVER;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [SLAVES-1:0]     slv_stb;
  logic [SLAVES-1:0]     slv_ack;
  logic [SLAVES*32-1:0]  slv_dat;

  wb_addr_dec_if bus ();

  wb_addr_dec #(
    .SLAVES (SLAVES),
    .SEL_HI (SEL_HI),
    .SEL_LO (SEL_LO),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .slv_stb_o(slv_stb),
    .slv_ack_i(slv_ack),
    .slv_dat_i(slv_dat)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_dat;        // model: dat_o holds the last response
  logic [29:0] last_err_adr;    // model: address of the last errored access

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Begin a new cycle: inputs change just after the rising edge, and outputs
  // are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [SLAVES-1:0] exp_stb,
                               input logic exp_ack, input logic exp_err);
    check({tag, " slv_stb"}, 64'(slv_stb), 64'(exp_stb));
    check({tag, " ack_o"},   64'(bus.ack_o), 64'(exp_ack));
    check({tag, " err_o"},   64'(bus.err_o), 64'(exp_err));
    check({tag, " dat_o"},   64'(bus.dat_o), 64'(last_dat));
    check({tag, " err_adr"}, 64'(bus.err_adr_o), 64'(last_err_adr));
  endtask

  task automatic randomize_slaves(input bit all_ack);
    for (int s = 0; s < SLAVES; s++) slv_dat[s*32 +: 32] = $urandom;
    slv_ack = all_ack ? '1 : SLAVES'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'($urandom);
      bus.adr_i = 30'($urandom);
      randomize_slaves(1'b0);
      @(negedge clk);
      check_outputs("idle", '0, 1'b0, 1'b0);
    end
  endtask

  // One transaction.
  //   k: cycle in which the selected slave acks (>= 1)
  //   a: cycle in which the master drops cyc (NEVER = no abort)
  task automatic run_txn(input logic [29:0] adr, input int k, input int a,
                         input bit noise_all, input bit stb_jitter);
    int                idx, kind, last, m;   // kind: 0 none, 1 ack, 2 err
    bit                mapped;
    logic [SLAVES-1:0] onehot;
    logic [31:0]       resp_dat;
    idx      = int'(adr[SEL_HI:SEL_LO]);
    mapped   = (idx < SLAVES);
    onehot   = '0;
    resp_dat = 32'd0;
    if (mapped) onehot[idx] = 1'b1;
    if (!mapped) begin
      kind = 2; last = 1;
    end else begin
      m = (k < a) ? k : a;
      if (T_EFF < m) m = T_EFF;
      if (k == m)      begin kind = 1; last = k + 1; end
      else if (a == m) begin kind = 0; last = a; end
      else             begin kind = 2; last = T_EFF + 1; end
    end
    $display("txn adr=%h idx=%0d k=%0d a=%0d expect=%s end_cycle=%0d",
             adr, idx, k, a, (kind == 1) ? "ack" : (kind == 2) ? "err" : "abort", last);
    for (int c = 0; c <= last; c++) begin
      bit                resp_c, active_c;
      logic              cyc_c, stb_c;
      logic [SLAVES-1:0] exp_stb;
      step();
      resp_c   = (kind != 0) && (c == last);
      active_c = mapped && (c >= 1) && !resp_c;
      if (c == 0)          begin cyc_c = 1'b1; stb_c = 1'b1; end
      else if (resp_c)     begin cyc_c = 1'($urandom); stb_c = 1'($urandom); end
      else if (c == a)     begin cyc_c = 1'b0; stb_c = 1'($urandom); end
      else                 begin cyc_c = 1'b1; stb_c = stb_jitter ? ($urandom_range(3) != 0) : 1'b1; end
      bus.cyc_i = cyc_c;
      bus.stb_i = stb_c;
      bus.adr_i = (c == 0) ? adr : 30'($urandom);
      randomize_slaves(noise_all);
      if (mapped && active_c) slv_ack[idx] = (c == k);
      if (mapped && c == k) resp_dat = slv_dat[idx*32 +: 32];
      @(negedge clk);
      exp_stb = (active_c && cyc_c && stb_c) ? onehot : '0;
      if (resp_c && kind == 1) last_dat = resp_dat;
      if (resp_c && kind == 2) begin last_dat = 32'd0; last_err_adr = adr; end
      check_outputs($sformatf("txn%0h c%0d", adr, c), exp_stb,
                    resp_c && (kind == 1), resp_c && (kind == 2));
    end
  endtask

  initial begin
    logic [29:0] adr;
    int          k, a;

    rst       = 1'b1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.adr_i = 30'h0800_0010;
    slv_ack   = '1;
    slv_dat   = '0;
    last_dat     = 32'd0;
    last_err_adr = 30'd0;

    // Reset holds everything at zero even while a request is presented.
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check_outputs("reset", '0, 1'b0, 1'b0);
    end
    step();
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    rst       = 1'b0;
    idle_cycles(2);

    // Slave 2 acks one cycle after its strobe.
    run_txn(30'h0800_0010, 2, NEVER, 1'b0, 1'b0);
    // idx 7 is unmapped with SLAVES=6.
    run_txn(30'h1C00_0000, 1, NEVER, 1'b0, 1'b0);
    // Slave 1 selected while all the others ack every cycle.
    run_txn(30'h0400_0044, 4, NEVER, 1'b1, 1'b0);
    // Master abort in cycle 2.
    run_txn(30'h0C00_0008, NEVER, 2, 1'b0, 1'b0);
    // Back-to-back requests to slaves 0 and 4 with an immediate ack.
    run_txn(30'h0000_0100, 1, NEVER, 1'b0, 1'b0);
    run_txn(30'h1000_0200, 1, NEVER, 1'b0, 1'b0);
    // Ack exactly in the last ACTIVE cycle, and one cycle too late.
    run_txn(30'h1400_0300, TIMEOUT, NEVER, 1'b0, 1'b0);
    run_txn(30'h1400_0304, TIMEOUT + 1, NEVER, 1'b0, 1'b0);
    // Very slow slave: this ends in a timeout error when the timeout is
    // built in, and in a late ack otherwise.
    run_txn(30'h0400_0ABC, 1005, NEVER, 1'b0, 1'b0);

    // Reset in the cycle the slave acks: the response is discarded.
    step();
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 30'h0800_0020; slv_ack = '0;
    @(negedge clk);
    check_outputs("rstmid c0", '0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    check_outputs("rstmid c1", 6'b000100, 1'b0, 1'b0);
    step();
    slv_ack = 6'b000100;
    rst     = 1'b1;
    @(negedge clk);
    check_outputs("rstmid c2", 6'b000100, 1'b0, 1'b0);
    step();
    rst = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0; slv_ack = '0;
    last_dat     = 32'd0;
    last_err_adr = 30'd0;
    @(negedge clk);
    check_outputs("rstmid c3", '0, 1'b0, 1'b0);
    idle_cycles(1);

    // Randomised traffic.
    for (int t = 0; t < 80; t++) begin
      adr = 30'($urandom);
      adr[SEL_HI:SEL_LO] = 4'($urandom_range(0, 15));
      k = $urandom_range(1, 9);
      a = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : NEVER;
      if (a == k) a = NEVER;
      run_txn(adr, k, a, ($urandom_range(0, 3) == 0), 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_addr_dec.md
# wb_addr_dec

Parametrised Wishbone address decoder and response multiplexer. It is the successor to the fixed-map decoder and peripheral arbiter between the request translator and the memory and peripheral slaves. It selects one of `SLAVES` targets from an address bit field and registers ack and read data. Unmapped accesses and (optionally) stalled slaves terminate with a bus error instead of hanging the CPU.

## Interface

Parameters:
- `SLAVES`, default 8: number of slave ports, 1..16.
- `SEL_HI`, default 29: MSB of the slave-index field in `adr_i`.
- `SEL_LO`, default 26: LSB of the slave-index field; field width must satisfy 2^(SEL_HI-SEL_LO+1) ≥ SLAVES.
- `TIMEOUT`, default 255: maximum ACTIVE cycles before error, 1..65535.

Ports:
- `clk_i`  in  1  system clock; the single clock domain.
- `rst_i`  in  1  reset; synchronous and active-high.
- `cyc_i`  in  1  master cycle.
- `stb_i`  in  1  master strobe.
- `adr_i`  in  30  word address.
- `ack_o`  out  1  registered acknowledge, one-cycle pulse.
- `err_o`  out  1  registered bus error, one-cycle pulse.
- `dat_o`  out  32  registered read data.
- `err_adr_o`  out  30  address of the most recent errored access.
- `slv_stb_o`  out  SLAVES  per-slave strobe, one-hot or zero.
- `slv_ack_i`  in  SLAVES  per-slave acknowledge.
- `slv_dat_i`  in  SLAVES*32  per-slave read data; slave n occupies `[n*32+31:n*32]`.

## Operation

- Slave index: `idx = adr_i[SEL_HI:SEL_LO]`. `idx ≥ SLAVES` is unmapped.
- FSM states are IDLE, ACTIVE and RESP.
- IDLE: on `cyc_i & stb_i`:
  - Latch `idx`.
  - Mapped: go to ACTIVE and clear the timeout counter.
  - Unmapped: go to RESP with error, and capture `adr_i` into `err_adr_o`.
- ACTIVE: `slv_stb_o[idx] = stb_i & cyc_i`, combinational from the state and the latched idx. All other strobe bits are 0.
  - `slv_ack_i[idx]` high: register `dat_o <= slv_dat_i[idx]`, then go to RESP with ack.
  - `cyc_i` low (master abort): go to IDLE. No ack and no err.
  - Otherwise increment the counter.
- RESP: exactly one of `ack_o` / `err_o` is high for this one cycle, and all `slv_stb_o` are 0.
  - `stb_i` is ignored in this cycle.
  - Next state is always IDLE.
- Acks from non-selected slaves are ignored in every state. Acks arriving in IDLE or RESP are ignored.
- An error response sets `dat_o <= 0`.
- `dat_o` holds its value between responses.
- Reset: state goes to IDLE and all outputs go to 0 on the clock edge with `rst_i` high. This applies mid-transaction as well.
  - `slv_stb_o` drops in the cycle after that edge.
  - A pending response is discarded.

## Timing

- Request first seen in IDLE at cycle 0.
- Mapped access: `slv_stb_o` is high from cycle 1.
  - Slave ack in cycle k (k ≥ 1) gives `ack_o` and valid `dat_o` in cycle k+1.
  - Minimum latency is 2 cycles.
- Unmapped access: `err_o` in cycle 1. The slave never sees a strobe.
- Back-to-back: after RESP in cycle r, a new request is accepted in IDLE at cycle r+1.
- Timeout (macro defined):
  - ACTIVE lasts at most `TIMEOUT` cycles, i.e. cycles 1..TIMEOUT.
  - With no ack by then, `err_o` fires in cycle TIMEOUT+1 and `err_adr_o` captures the latched address.
  - An ack in the last ACTIVE cycle wins over the timeout.
- The counter is 16 bits and never wraps. It saturates at `TIMEOUT-1` before the exit.

## Configuration

- `WB_ADDR_DEC_TIMEOUT_EN` defined: the timeout counter and timeout error path are compiled in.
- Not defined:
  - No counter logic exists and `TIMEOUT` is unused.
  - ACTIVE waits indefinitely for ack or abort.
  - `err_o` and `err_adr_o` are driven by unmapped accesses only.

## Test plan

- Reset with SLAVES=8: all outputs 0. Request to `adr_i=30'h0800_0010` (idx 2) with slave 2 acking one cycle after its strobe carrying `32'hCAFE_0002` → `slv_stb_o=8'b0000_0100` from cycle 1, `ack_o` in cycle 3 with `dat_o=32'hCAFE_0002`.
- SLAVES=5, `adr_i=30'h1C00_0000` (idx 7) → `err_o` in cycle 1, `slv_stb_o` stays 0, `err_adr_o=30'h1C00_0000`, `dat_o=0`.
- Macro defined, TIMEOUT=4, slave never acks → `slv_stb_o` high in cycles 1..4, `err_o` in cycle 5, then accept a new request in cycle 6. Macro undefined: no `err_o` after 1000 cycles.
- Slave 1 selected while slave 0 and slave 3 assert ack every cycle → no `ack_o` until slave 1 acks. `dat_o` equals slave 1's data.
- Master drops `cyc_i` in cycle 2 of ACTIVE → `slv_stb_o=0` from cycle 2, no `ack_o`/`err_o`, IDLE in cycle 3. Separately, `rst_i` in ACTIVE → no response, all outputs 0 after the edge.
- Two back-to-back requests to slaves 0 and 4 with a combinational ack → `ack_o` pulses in cycles 2 and 5, no double strobe during either RESP cycle.
